// File: rtl/iter_shift_ctrl.sv
// Iterative RV32 shift sequencer (SLL/SRL/SRA), SHIFT_STEP positions per cycle.
// Optional: define ITER_SHIFT_ZERO_BYPASS_EN for single-cycle sa==0 / reserved-op completion.
module iter_shift_ctrl #(
  parameter int unsigned operand_width = 32,
  parameter int unsigned Sa_width      = 5,
  parameter int unsigned SHIFT_STEP    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [1:0]               op_in,
  input  logic [operand_width-1:0] src_in,
  input  logic [Sa_width-1:0]      sa_in,
  input  logic                     flush_in,
  output logic                     busy_out,
  output logic                     stall_out,
  output logic                     done_out,
  output logic [operand_width-1:0] result_out
);

  // One extra bit so SHIFT_STEP == operand_width is representable
  localparam int unsigned CntW = Sa_width + 1;
  localparam logic [CntW-1:0] StepC = CntW'(SHIFT_STEP);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [operand_width-1:0] acc_q, acc_d;
  logic [1:0]               op_q, op_d;
  logic [Sa_width-1:0]      cnt_q, cnt_d;
  logic [operand_width-1:0] result_q, result_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     bypass_c;
  logic                     stall_c;
  logic [CntW-1:0]          shamt_c;

  function automatic logic [operand_width-1:0] shift_acc(
    input logic [operand_width-1:0] val,
    input logic [1:0]               op,
    input logic [CntW-1:0]          amt
  );
    logic signed [operand_width-1:0] sval;
    logic [operand_width-1:0]        res;
    sval = $signed(val);
    case (op)
      OpSll:   res = val << amt;
      OpSrl:   res = val >> amt;
      OpSra:   res = operand_width'(sval >>> amt);
      default: res = val;
    endcase
    return res;
  endfunction

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    bypass_c = 1'b0;
    shamt_c  = '0;

    if (flush_in) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
`ifdef ITER_SHIFT_ZERO_BYPASS_EN
            if ((sa_in == '0) || (op_in == OpRsv)) begin
              bypass_c = 1'b1;
              result_d = src_in;
            end else begin
              state_d = ST_SHIFT;
              acc_d   = src_in;
              op_d    = op_in;
              cnt_d   = sa_in;
            end
`else
            state_d = ST_SHIFT;
            op_d    = op_in;
            if (op_in == OpRsv) begin
              cnt_d = '0;
            end else begin
              acc_d = src_in;
              cnt_d = sa_in;
            end
`endif
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = acc_q;
          end else begin
            shamt_c = ({1'b0, cnt_q} >= StepC) ? StepC : {1'b0, cnt_q};
            acc_d   = shift_acc(acc_q, op_q, shamt_c);
            cnt_d   = cnt_q - Sa_width'(shamt_c);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    stall_c = (start_in && (state_q == ST_IDLE) && !bypass_c) || (state_q == ST_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_out   = busy_q;
  assign stall_out  = stall_c;
  assign result_out = result_q;
`ifdef ITER_SHIFT_ZERO_BYPASS_EN
  assign done_out   = done_q | bypass_c;
`else
  assign done_out   = done_q;
`endif

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Scoreboard bench for iter_shift_ctrl: STEP=1 main instance plus a STEP=4 instance.
module tb_iter_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in, start4;
  logic [1:0]  op_in;
  logic [31:0] src_in;
  logic [4:0]  sa_in;
  logic        flush_in, flush4;
  logic        busy_out, stall_out, done_out;
  logic [31:0] result_out;
  logic        busy4, stall4, done4;
  logic [31:0] result4;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_shift_ctrl #(.operand_width(32), .Sa_width(5), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .op_in(op_in), .src_in(src_in),
    .sa_in(sa_in), .flush_in(flush_in), .busy_out(busy_out), .stall_out(stall_out),
    .done_out(done_out), .result_out(result_out)
  );

  iter_shift_ctrl #(.operand_width(32), .Sa_width(5), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start_in(start4), .op_in(op_in), .src_in(src_in),
    .sa_in(sa_in), .flush_in(flush4), .busy_out(busy4), .stall_out(stall4),
    .done_out(done4), .result_out(result4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bit-serial reference shift
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] src,
                                           input int sa);
    logic [31:0] r;
    r = src;
    for (int i = 0; i < sa; i++) begin
      case (op)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Scoreboard monitor: compare every done pulse of the main instance
  always @(negedge clk) begin
    if (!rst && done_out) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("result", result_out, e.res);
        check_val("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  // Caller must be 1 time unit after a posedge; returns likewise, in the cycle after DONE
  task automatic do_op(input logic [1:0] op, input logic [31:0] src, input logic [4:0] sa);
    exp_t e;
    int   target;
    bit   seen;
    e.res       = ref_shift(op, src, int'(sa));
    e.start_cyc = cyc;
    e.lat       = int'(sa) + 2;
    exp_q.push_back(e);
    target   = done_cnt + 1;
    op_in    = op;
    src_in   = src;
    sa_in    = sa;
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    src_in   = $urandom;
    sa_in    = 5'($urandom);
    seen     = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done_cnt >= target) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op4(input logic [1:0] op, input logic [31:0] src, input logic [4:0] sa,
                        input logic [31:0] exp_res, input int exp_lat);
    int  n;
    bit  seen;
    op_in  = op;
    src_in = src;
    sa_in  = sa;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check_val("step4_busy", 32'(busy4), 32'd1);
    n    = 1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!seen) check_val("step4_timeout", 32'd0, 32'd1);
    check_val("step4_result", result4, exp_res);
    check_val("step4_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int          dc;
    logic [31:0] last_res;
    rst = 1'b1; start_in = 1'b0; start4 = 1'b0; flush_in = 1'b0; flush4 = 1'b0;
    op_in = 2'b00; src_in = '0; sa_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check_val("rst_busy", 32'(busy_out), 32'd0);
    check_val("rst_done", 32'(done_out), 32'd0);
    check_val("rst_result", result_out, 32'd0);
    check_val("rst_stall", 32'(stall_out), 32'd0);

    do_op(2'b00, 32'h0000_0001, 5'd31);
    do_op(2'b10, 32'h8000_00F0, 5'd4);
    do_op(2'b01, 32'h8000_00F0, 5'd4);

    // sa=0: stall in start cycle, done two cycles later
    op_in = 2'b00; src_in = 32'h1234_5678; sa_in = 5'd0;
    #3 check_val("sa0_stall_comb", 32'(stall_out), 32'd0);
    start_in = 1'b1;
    #1 check_val("sa0_stall", 32'(stall_out), 32'd1);
    start_in = 1'b0;
    #1;
    do_op(2'b00, 32'h1234_5678, 5'd0);

    // Start while busy is ignored
    dc = done_cnt;
    exp_q.push_back('{ref_shift(2'b01, 32'hFFFF_FFFF, 5), cyc, 7});
    op_in = 2'b01; src_in = 32'hFFFF_FFFF; sa_in = 5'd5; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(posedge clk); #1;
    check_val("busy_mid", 32'(busy_out), 32'd1);
    check_val("stall_mid", 32'(stall_out), 32'd1);
    op_in = 2'b00; src_in = 32'h0; sa_in = 5'd1; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check_val("ignored_start_dones", 32'(done_cnt - dc), 32'd1);
    check_val("busy_idle", 32'(busy_out), 32'd0);
    do_op(2'b00, 32'h0000_000F, 5'd4);
    last_res = 32'h0000_00F0;

    // Flush in cycle 3 of SLL sa=10
    dc = done_cnt;
    op_in = 2'b00; src_in = 32'h0000_0003; sa_in = 5'd10; start_in = 1'b1;
    @(posedge clk); #1; start_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; flush_in = 1'b1;
    @(posedge clk); #1; flush_in = 1'b0;
    check_val("flush_busy", 32'(busy_out), 32'd0);
    check_val("flush_result", result_out, last_res);
    do_op(2'b00, 32'h0000_0005, 5'd2);
    repeat (12) begin @(posedge clk); #1; end
    check_val("flush_dones", 32'(done_cnt - dc), 32'd1);

    // Random back-to-back operations
    for (int i = 0; i < 6; i++) begin
      do_op(2'($urandom_range(0, 2)), $urandom, 5'($urandom));
    end

    // Reset mid-shift is asynchronous
    dc = done_cnt;
    op_in = 2'b00; src_in = 32'h0000_0001; sa_in = 5'd20; start_in = 1'b1;
    @(posedge clk); #1; start_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_val("pre_rst_busy", 32'(busy_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", 32'(busy_out), 32'd0);
    check_val("arst_done", 32'(done_out), 32'd0);
    check_val("arst_result", result_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    check_val("rst_no_done", 32'(done_cnt - dc), 32'd0);
    check_val("rst_result_hold", result_out, 32'd0);

    // SHIFT_STEP=4 instance
    do_op4(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 10);
    do_op4(2'b10, 32'h8000_0000, 5'd6, 32'hFE00_0000, 4);
    do_op4(2'b01, 32'hABCD_1234, 5'd0, 32'hABCD_1234, 2);

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
